rr_phase_arbiter: RTL
=====================

// Module: rr_phase_arbiter
// PURPOSE
//  Round-robin arbiter that shares one 4-phase sequencer resource between 4 requesters.
//  Grants one requester at a time, holds the grant until release or timeout, then rotates priority.
//  Sits between the requester agents and the phase-sequencer datapath; gnt_id steers the shared sequencer.
// PARAMETERS
//  N_REQ     4   number of requesters (fixed at 4; gnt_id is 2 bits)
//  MAX_HOLD  8   max cycles one grant is held before forced release (>=2)
//  HOLD_W    4   width of hold counter; must hold MAX_HOLD
// PORTS
//  clk      in   1      single clock, all state changes on posedge
//  rst      in   1      synchronous, active-high reset
//  req      in   4      request per requester, level, held until served
//  done     in   4      release pulse per requester; only done[gnt_id] while granted counts
//  gnt      out  4      one-hot grant, registered; 0 when no grant
//  gnt_id   out  2      index of granted requester, valid while busy=1
//  busy     out  1      1 while in GRANT state
//  timeout  out  1      1-cycle pulse when a grant is force-released at MAX_HOLD
// BEHAVIOUR
//  Reset (rst=1 at posedge): state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, hold_cnt=0, last_ptr=3 (req0 highest priority next).
//  States: IDLE -> GRANT -> GAP -> IDLE; 2-bit encoding IDLE=00, GRANT=01, GAP=10; 11 illegal -> IDLE.
//  IDLE: if |req: pick first set bit scanning last_ptr+1, +2, +3, +4 (mod 4); next edge gnt, gnt_id, busy=1,
//   last_ptr<=picked, hold_cnt<=1, state<=GRANT. If req==0 stay IDLE, outputs 0.
//  Grant latency: req sampled in IDLE at edge t -> gnt visible after edge t+1 (1 cycle).
//  GRANT: release when done[gnt_id]=1, or req[gnt_id]=0, or hold_cnt==MAX_HOLD.
//   On release: gnt<=0, busy<=0, state<=GAP; timeout<=1 only if release cause is hold_cnt==MAX_HOLD
//   and neither done[gnt_id] nor req drop occurred that cycle (voluntary release wins).
//   Otherwise hold_cnt<=hold_cnt+1, grant unchanged.
//  GAP: exactly one cycle with gnt=0 (sequencer turnaround); timeout returns to 0; state<=IDLE.
//   Back-to-back requests: min spacing between two grants is 2 idle cycles (GAP + IDLE arbitration).
//  done bits for non-granted requesters, and done in IDLE/GAP, are ignored.
//  req changes on non-granted lines during GRANT do not affect current grant; sampled at next IDLE.
//  last_ptr wraps 3->0; with one persistent requester it is re-granted every 3rd+ cycle after release.
//  Reset mid-grant: gnt, busy, timeout cleared at that same edge; no timeout pulse; priority returns to req0.
//  gnt is always one-hot or zero; gnt == (busy ? 1<<gnt_id : 0).
// STRUCTURE
//  Shared package rr_arb_pkg: state encodings (ST_IDLE/ST_GRANT/ST_GAP), N_REQ, default MAX_HOLD.
//  One sub-module rr_pick4: combinational rotate-priority picker (req[3:0], last_ptr[1:0] -> valid, idx[1:0]).
//  Top holds state register, hold counter, last_ptr, registered outputs.
// TESTING
//  Reset then req=4'b1111 held -> grants rotate id 0,1,2,3,0 with done pulses; 1 GAP + 1 IDLE between each.
//  req=4'b0100 only, never done, MAX_HOLD=8 -> gnt=4'b0100 for 8 cycles, timeout=1 on GAP cycle, then re-grant id2.
//  Grant id1 active, done[1]=1 on cycle hold_cnt==MAX_HOLD -> release, timeout stays 0.
//  Grant id0 active, done[3]=1 and req[2] toggling -> grant id0 unaffected; next grant id2 if req[2]=1 in IDLE.
//  Grant id3 active at hold_cnt=4, rst=1 one cycle -> gnt=0, busy=0, timeout=0 next cycle; req=4'b1010 -> id1 granted.
//  Grant id2, req[2] deasserted without done -> release next edge, GAP, no timeout; last_ptr=2 so id3 next.

Source files
------------

// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared encodings and helpers for the round-robin phase arbiter
package rr_arb_pkg;

    localparam int N_REQ        = 4;
    localparam int MAX_HOLD_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_GRANT = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    // Modulo-4 pointer arithmetic; the 2-bit result wraps naturally.
    function automatic logic [1:0] wrap_add(input logic [1:0] a, input logic [1:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational rotate-priority picker, scans last_ptr+1 .. last_ptr+4
import rr_arb_pkg::*;

module rr_pick4 (
    input  logic [N_REQ-1:0] i_req,
    input  logic [1:0]       i_last_ptr,
    output logic             o_valid,
    output logic [1:0]       o_idx
);

    // Walk from the farthest candidate back to the nearest so the nearest set bit wins.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = i_last_ptr;
        for (int k = N_REQ; k >= 1; k--) begin
            if (i_req[wrap_add(i_last_ptr, 2'(k))]) begin
                o_valid = 1'b1;
                o_idx   = wrap_add(i_last_ptr, 2'(k));
            end
        end
    end

endmodule

// File: rtl/rr_phase_arbiter.sv
// rtl/rr_phase_arbiter.sv - round-robin arbiter sharing one 4-phase sequencer among 4 requesters
import rr_arb_pkg::*;

module rr_phase_arbiter #(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int HOLD_W   = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_req,
    input  logic [N_REQ-1:0] i_done,
    output logic [N_REQ-1:0] o_gnt,
    output logic [1:0]       o_gnt_id,
    output logic             o_busy,
    output logic             o_timeout
);

    state_t             r_state;
    logic [N_REQ-1:0]   r_gnt;
    logic [1:0]         r_gnt_id;
    logic               r_busy;
    logic               r_timeout;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic [1:0]         r_last_ptr;

    logic               w_valid;
    logic [1:0]         w_idx;
    logic               w_voluntary;
    logic               w_hold_exp;
    logic               w_release;

    rr_pick4 u_pick (
        .i_req      (i_req),
        .i_last_ptr (r_last_ptr),
        .o_valid    (w_valid),
        .o_idx      (w_idx)
    );

    // A done pulse or request drop on the owner outranks the hold limit for the timeout flag.
    assign w_voluntary = i_done[r_gnt_id] | ~i_req[r_gnt_id];
    assign w_hold_exp  = (r_hold_cnt == HOLD_W'(MAX_HOLD));
    assign w_release   = w_voluntary | w_hold_exp;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_gnt      <= '0;
            r_gnt_id   <= 2'd0;
            r_busy     <= 1'b0;
            r_timeout  <= 1'b0;
            r_hold_cnt <= '0;
            r_last_ptr <= 2'd3;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_timeout <= 1'b0;
                    if (w_valid) begin
                        r_gnt      <= N_REQ'(1) << w_idx;
                        r_gnt_id   <= w_idx;
                        r_busy     <= 1'b1;
                        r_last_ptr <= w_idx;
                        r_hold_cnt <= HOLD_W'(1);
                        r_state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_release) begin
                        r_gnt      <= '0;
                        r_busy     <= 1'b0;
                        r_timeout  <= w_hold_exp & ~w_voluntary;
                        r_hold_cnt <= '0;
                        r_state    <= ST_GAP;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
                    end
                end
                ST_GAP: begin
                    r_timeout <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_gnt      <= '0;
                    r_busy     <= 1'b0;
                    r_timeout  <= 1'b0;
                    r_hold_cnt <= '0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_gnt     = r_gnt;
    assign o_gnt_id  = r_gnt_id;
    assign o_busy    = r_busy;
    assign o_timeout = r_timeout;

endmodule
